sdram_port_scheduler: RTL and testbench
=======================================

Name: sdram_port_scheduler

Overview:
- Round-robin scheduler with read priority for the 4-port SDRAM controller. Two write FIFOs and two read FIFOs share one SDRAM command path.
- Decides which port gets the next burst and issues the burst request (mRD/mWR, mADDR, mLENGTH, port masks) to the burst sequencer.
- Keeps a rolling, wrapping address pointer for each port.
- Adds write-starvation protection to the fixed read-over-write policy.

Parameters:
- ASIZE, 23, SDRAM word address width
- LSIZE, 9, burst length width
- USEDW_W, 16, FIFO used-word width
- STARVE_LIMIT, 4, consecutive read grants allowed while a write is eligible

Ports:
- CLK  in  1  controller clock
- RESET_N  in  1  asynchronous active-low reset
- WR1_ADDR, WR2_ADDR, RD1_ADDR, RD2_ADDR  in  ASIZE  per-port start address
- WR1_MAX_ADDR, WR2_MAX_ADDR, RD1_MAX_ADDR, RD2_MAX_ADDR  in  ASIZE  per-port max address
- WR1_LENGTH, WR2_LENGTH, RD1_LENGTH, RD2_LENGTH  in  LSIZE  per-port burst length
- WR1_LOAD, WR2_LOAD, RD1_LOAD, RD2_LOAD  in  1  reload pointer to start address
- WR1_LEVEL, WR2_LEVEL  in  USEDW_W  write-FIFO read-side used words
- RD1_LEVEL, RD2_LEVEL  in  USEDW_W  read-FIFO write-side used words
- SEQ_IDLE  in  1  burst sequencer idle (state 0)
- WR_DONE, RD_DONE  in  1  one-cycle burst-complete pulses
- mWR, mRD  out  1  burst request levels
- mADDR  out  ASIZE  burst start address
- mLENGTH  out  LSIZE  burst length
- WR_MASK, RD_MASK  out  2  one-hot active port; bit0 = port 1
- STARVE_CNT  out  3  debug: current starvation count

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, state IDLE, RR pointers to port 1, all four pointers marked FRESH.
- Effective address of a port = its start address when FRESH, otherwise its pointer.
- Eligibility:
  - Read n: RDn_LEVEL < RDn_LENGTH and RDn_LENGTH != 0.
  - Write n: WRn_LEVEL >= WRn_LENGTH and WRn_LENGTH != 0.
  - A port whose LOAD is high this cycle is not eligible.
- State IDLE:
  - Evaluates only when SEQ_IDLE=1, mWR=0, mRD=0, and no LOAD is high.
  - If none eligible, stay in IDLE.
  - Class choice is read unless (STARVE_CNT >= STARVE_LIMIT and a write is eligible). If no read is eligible, choose write.
  - Within a class, round-robin: grant the port after the last granted port of that class, otherwise the other one.
  - Go to GRANT.
- State GRANT (1 cycle):
  - Register mADDR = effective address, mLENGTH = port LENGTH, and the one-hot mask.
  - Assert mRD or mWR from the next edge.
  - Update the class RR pointer.
  - Starvation counter: read grant while a write was eligible increments it, saturating at 7; any write grant clears it; read grant with no write eligible leaves it unchanged.
  - Go to BUSY.
- State BUSY:
  - Hold all request outputs stable.
  - On the DONE pulse matching the active class (RD_DONE for RD_MASK!=0, WR_DONE for WR_MASK!=0): deassert mRD/mWR, clear masks, advance the granted pointer, go to GAP.
  - Non-matching DONE pulses are ignored.
- Pointer advance:
  - Compute in ASIZE+1 bits: if addr + LENGTH < MAX_ADDR then pointer = addr + LENGTH, else pointer = start address (wrap). If LENGTH > MAX_ADDR, always wrap.
  - Clear the port's FRESH flag.
- State GAP: one cycle with request low so the sequencer's edge detector re-arms. Then IDLE.
- LOAD handling:
  - LOADn sets the FRESH flag in any state.
  - If LOADn coincides with that port's DONE, LOAD wins and no advance occurs.
  - LOAD never aborts an active burst.
- Latency: eligible in IDLE -> mRD/mWR high 2 cycles later.
- Simultaneous RD_DONE and WR_DONE: only the matching one is acted on.
- Reset mid-burst: outputs drop to 0 immediately; pointers become FRESH.

Test Plan:
- Lengths 256, RD1_LEVEL=0, others idle -> mRD=1, RD_MASK=01, mADDR=RD1_ADDR, mLENGTH=256, two cycles after SEQ_IDLE; RD_DONE -> mRD=0, one GAP cycle, next RD1 grant at RD1_ADDR+256.
- Both reads eligible, continuous -> grants alternate RD1, RD2, RD1, RD2.
- Both reads permanently eligible, WR1_LEVEL=300 >= 256 -> exactly 4 read grants, then one WR1 grant (WR_MASK=01), STARVE_CNT returns to 0.
- RD1_ADDR=0, MAX=0x200, LENGTH=0x100 -> addresses 0x000, 0x100, 0x000 (wrap because 0x100+0x100 is not < 0x200).
- WR2_LOAD pulsed in the same cycle as WR_DONE for a WR2 burst at 0x400 -> no advance; next WR2 grant at WR2_ADDR.
- RESET_N low during BUSY -> mWR, mRD, masks = 0 asynchronously; after release, first grant uses the start address.

Source files
------------

// File: rtl/sdram_port_scheduler_if.sv
// rtl/sdram_port_scheduler_if.sv - port-side and sequencer-side signals of the SDRAM port scheduler
interface sdram_port_scheduler_if #(
    parameter int ASIZE   = 23,
    parameter int LSIZE   = 9,
    parameter int USEDW_W = 16
);
    logic [ASIZE-1:0]   WR1_ADDR, WR2_ADDR, RD1_ADDR, RD2_ADDR;
    logic [ASIZE-1:0]   WR1_MAX_ADDR, WR2_MAX_ADDR, RD1_MAX_ADDR, RD2_MAX_ADDR;
    logic [LSIZE-1:0]   WR1_LENGTH, WR2_LENGTH, RD1_LENGTH, RD2_LENGTH;
    logic               WR1_LOAD, WR2_LOAD, RD1_LOAD, RD2_LOAD;
    logic [USEDW_W-1:0] WR1_LEVEL, WR2_LEVEL, RD1_LEVEL, RD2_LEVEL;
    logic               SEQ_IDLE;
    logic               WR_DONE, RD_DONE;
    logic               mWR, mRD;
    logic [ASIZE-1:0]   mADDR;
    logic [LSIZE-1:0]   mLENGTH;
    logic [1:0]         WR_MASK, RD_MASK;
    logic [2:0]         STARVE_CNT;

    modport slave (
        input  WR1_ADDR, WR2_ADDR, RD1_ADDR, RD2_ADDR,
        input  WR1_MAX_ADDR, WR2_MAX_ADDR, RD1_MAX_ADDR, RD2_MAX_ADDR,
        input  WR1_LENGTH, WR2_LENGTH, RD1_LENGTH, RD2_LENGTH,
        input  WR1_LOAD, WR2_LOAD, RD1_LOAD, RD2_LOAD,
        input  WR1_LEVEL, WR2_LEVEL, RD1_LEVEL, RD2_LEVEL,
        input  SEQ_IDLE, WR_DONE, RD_DONE,
        output mWR, mRD, mADDR, mLENGTH, WR_MASK, RD_MASK, STARVE_CNT
    );

    modport master (
        output WR1_ADDR, WR2_ADDR, RD1_ADDR, RD2_ADDR,
        output WR1_MAX_ADDR, WR2_MAX_ADDR, RD1_MAX_ADDR, RD2_MAX_ADDR,
        output WR1_LENGTH, WR2_LENGTH, RD1_LENGTH, RD2_LENGTH,
        output WR1_LOAD, WR2_LOAD, RD1_LOAD, RD2_LOAD,
        output WR1_LEVEL, WR2_LEVEL, RD1_LEVEL, RD2_LEVEL,
        output SEQ_IDLE, WR_DONE, RD_DONE,
        input  mWR, mRD, mADDR, mLENGTH, WR_MASK, RD_MASK, STARVE_CNT
    );
endinterface

// File: rtl/sdram_port_scheduler.sv
// rtl/sdram_port_scheduler.sv - round-robin, read-priority burst scheduler with write-starvation guard
module sdram_port_scheduler #(
    parameter int ASIZE        = 23,
    parameter int LSIZE        = 9,
    parameter int USEDW_W      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    sdram_port_scheduler_if.slave bus
);
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_GAP} state_t;

    // Port index order used throughout: 0=WR1, 1=WR2, 2=RD1, 3=RD2
    state_t             state_q, state_d;
    logic               sel_wr_q, sel_wr_d;
    logic               sel_port_q, sel_port_d;
    logic               wr_elig_q, wr_elig_d;
    logic               rd_next_q, rd_next_d;
    logic               wr_next_q, wr_next_d;
    logic [2:0]         starve_q, starve_d;
    logic [ASIZE-1:0]   ptr_q [4];
    logic [ASIZE-1:0]   ptr_d [4];
    logic [3:0]         fresh_q, fresh_d;
    logic               m_wr_q, m_wr_d;
    logic               m_rd_q, m_rd_d;
    logic [ASIZE-1:0]   m_addr_q, m_addr_d;
    logic [LSIZE-1:0]   m_len_q, m_len_d;
    logic [1:0]         wr_mask_q, wr_mask_d;
    logic [1:0]         rd_mask_q, rd_mask_d;

    logic [ASIZE-1:0]   start_a [4];
    logic [ASIZE-1:0]   max_a [4];
    logic [LSIZE-1:0]   len_a [4];
    logic [USEDW_W-1:0] level_a [4];
    logic [3:0]         load_a;
    logic [3:0]         elig;
    logic               rd_any, wr_any;
    logic [1:0]         sel_idx;
    logic [ASIZE:0]     adv_sum;

    // Gather the per-port controls into arrays so the scheduling logic can index them
    always_comb begin
        start_a[0] = bus.WR1_ADDR;     start_a[1] = bus.WR2_ADDR;
        start_a[2] = bus.RD1_ADDR;     start_a[3] = bus.RD2_ADDR;
        max_a[0]   = bus.WR1_MAX_ADDR; max_a[1]   = bus.WR2_MAX_ADDR;
        max_a[2]   = bus.RD1_MAX_ADDR; max_a[3]   = bus.RD2_MAX_ADDR;
        len_a[0]   = bus.WR1_LENGTH;   len_a[1]   = bus.WR2_LENGTH;
        len_a[2]   = bus.RD1_LENGTH;   len_a[3]   = bus.RD2_LENGTH;
        level_a[0] = bus.WR1_LEVEL;    level_a[1] = bus.WR2_LEVEL;
        level_a[2] = bus.RD1_LEVEL;    level_a[3] = bus.RD2_LEVEL;
        load_a     = {bus.RD2_LOAD, bus.RD1_LOAD, bus.WR2_LOAD, bus.WR1_LOAD};
    end

    // Writes need a full burst buffered; reads need room for a full burst; a reloading port waits
    always_comb begin
        elig = '0;
        for (int i = 0; i < 2; i++)
            elig[i] = (level_a[i] >= USEDW_W'(len_a[i])) && (len_a[i] != '0) && !load_a[i];
        for (int i = 2; i < 4; i++)
            elig[i] = (level_a[i] < USEDW_W'(len_a[i])) && (len_a[i] != '0) && !load_a[i];
        wr_any  = elig[0] | elig[1];
        rd_any  = elig[2] | elig[3];
        sel_idx = {~sel_wr_q, sel_port_q};
        adv_sum = {1'b0, m_addr_q} + (ASIZE + 1)'(m_len_q);
    end

    // Scheduler FSM: arbitrate in IDLE, latch the request in GRANT, wait for DONE in BUSY
    always_comb begin
        state_d    = state_q;
        sel_wr_d   = sel_wr_q;
        sel_port_d = sel_port_q;
        wr_elig_d  = wr_elig_q;
        rd_next_d  = rd_next_q;
        wr_next_d  = wr_next_q;
        starve_d   = starve_q;
        ptr_d      = ptr_q;
        fresh_d    = fresh_q;
        m_wr_d     = m_wr_q;
        m_rd_d     = m_rd_q;
        m_addr_d   = m_addr_q;
        m_len_d    = m_len_q;
        wr_mask_d  = wr_mask_q;
        rd_mask_d  = rd_mask_q;

        case (state_q)
            S_IDLE: begin
                if (bus.SEQ_IDLE && !m_wr_q && !m_rd_q && (load_a == 4'b0) && (elig != 4'b0)) begin
                    wr_elig_d = wr_any;
                    if (!rd_any || ((starve_q >= STARVE_LIM) && wr_any)) begin
                        sel_wr_d   = 1'b1;
                        sel_port_d = wr_next_q ? elig[1] : ~elig[0];
                    end else begin
                        sel_wr_d   = 1'b0;
                        sel_port_d = rd_next_q ? elig[3] : ~elig[2];
                    end
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // A reload landing in this very cycle still restarts from the start address
                m_addr_d = (fresh_q[sel_idx] || load_a[sel_idx]) ? start_a[sel_idx] : ptr_q[sel_idx];
                m_len_d  = len_a[sel_idx];
                if (sel_wr_q) begin
                    m_wr_d    = 1'b1;
                    wr_mask_d = sel_port_q ? 2'b10 : 2'b01;
                    wr_next_d = ~sel_port_q;
                    starve_d  = 3'd0;
                end else begin
                    m_rd_d    = 1'b1;
                    rd_mask_d = sel_port_q ? 2'b10 : 2'b01;
                    rd_next_d = ~sel_port_q;
                    if (wr_elig_q && (starve_q != 3'd7))
                        starve_d = starve_q + 3'd1;
                end
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (sel_wr_q ? bus.WR_DONE : bus.RD_DONE) begin
                    m_wr_d    = 1'b0;
                    m_rd_d    = 1'b0;
                    wr_mask_d = 2'b00;
                    rd_mask_d = 2'b00;
                    if (!load_a[sel_idx]) begin
                        ptr_d[sel_idx]   = (adv_sum < {1'b0, max_a[sel_idx]}) ?
                                           adv_sum[ASIZE-1:0] : start_a[sel_idx];
                        fresh_d[sel_idx] = 1'b0;
                    end
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        fresh_d = fresh_d | load_a;
    end

    // State and request registers; reset drops requests at once and marks every pointer fresh
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            sel_wr_q   <= 1'b0;
            sel_port_q <= 1'b0;
            wr_elig_q  <= 1'b0;
            rd_next_q  <= 1'b0;
            wr_next_q  <= 1'b0;
            starve_q   <= 3'd0;
            for (int i = 0; i < 4; i++) ptr_q[i] <= '0;
            fresh_q    <= 4'hF;
            m_wr_q     <= 1'b0;
            m_rd_q     <= 1'b0;
            m_addr_q   <= '0;
            m_len_q    <= '0;
            wr_mask_q  <= 2'b00;
            rd_mask_q  <= 2'b00;
        end else begin
            state_q    <= state_d;
            sel_wr_q   <= sel_wr_d;
            sel_port_q <= sel_port_d;
            wr_elig_q  <= wr_elig_d;
            rd_next_q  <= rd_next_d;
            wr_next_q  <= wr_next_d;
            starve_q   <= starve_d;
            ptr_q      <= ptr_d;
            fresh_q    <= fresh_d;
            m_wr_q     <= m_wr_d;
            m_rd_q     <= m_rd_d;
            m_addr_q   <= m_addr_d;
            m_len_q    <= m_len_d;
            wr_mask_q  <= wr_mask_d;
            rd_mask_q  <= rd_mask_d;
        end
    end

    assign bus.mWR        = m_wr_q;
    assign bus.mRD        = m_rd_q;
    assign bus.mADDR      = m_addr_q;
    assign bus.mLENGTH    = m_len_q;
    assign bus.WR_MASK    = wr_mask_q;
    assign bus.RD_MASK    = rd_mask_q;
    assign bus.STARVE_CNT = starve_q;
endmodule

// File: tb/tb_sdram_port_scheduler.sv
// tb/tb_sdram_port_scheduler.sv - directed self-checking bench for sdram_port_scheduler
module tb_sdram_port_scheduler;
    logic CLK;
    logic RESET_N;
    int   vectors;
    int   miscompares;

    sdram_port_scheduler_if bus ();

    sdram_port_scheduler dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mRD || bus.mWR) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_done(input bit is_wr, input bit load_wr2);
        if (is_wr) bus.WR_DONE = 1'b1;
        else       bus.RD_DONE = 1'b1;
        bus.WR2_LOAD = load_wr2;
        tick();
        bus.WR_DONE  = 1'b0;
        bus.RD_DONE  = 1'b0;
        bus.WR2_LOAD = 1'b0;
    endtask

    task automatic do_reset();
        bus.WR1_ADDR = '0; bus.WR2_ADDR = '0; bus.RD1_ADDR = '0; bus.RD2_ADDR = '0;
        bus.WR1_MAX_ADDR = '0; bus.WR2_MAX_ADDR = '0; bus.RD1_MAX_ADDR = '0; bus.RD2_MAX_ADDR = '0;
        bus.WR1_LENGTH = '0; bus.WR2_LENGTH = '0; bus.RD1_LENGTH = '0; bus.RD2_LENGTH = '0;
        bus.WR1_LOAD = 1'b0; bus.WR2_LOAD = 1'b0; bus.RD1_LOAD = 1'b0; bus.RD2_LOAD = 1'b0;
        bus.WR1_LEVEL = '0; bus.WR2_LEVEL = '0; bus.RD1_LEVEL = '0; bus.RD2_LEVEL = '0;
        bus.SEQ_IDLE = 1'b0; bus.WR_DONE = 1'b0; bus.RD_DONE = 1'b0;
        RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({bus.mWR, bus.mRD, bus.WR_MASK, bus.RD_MASK, bus.STARVE_CNT} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl mWR=%0b mRD=%0b WR_MASK=%b RD_MASK=%b STARVE=%0d expected all 0",
                     bus.mWR, bus.mRD, bus.WR_MASK, bus.RD_MASK, bus.STARVE_CNT);
        end
        vectors++;
        if (bus.mADDR !== 23'h0 || bus.mLENGTH !== 9'h0) begin
            miscompares++;
            $display("FAIL reset_bus mADDR=%h mLENGTH=%0d expected 0 0", bus.mADDR, bus.mLENGTH);
        end
    endtask

    task automatic test_basic();
        do_reset();
        bus.RD1_ADDR = 23'h1000; bus.RD1_MAX_ADDR = 23'h10000; bus.RD1_LENGTH = 9'd256;
        bus.SEQ_IDLE = 1'b1;
        tick();
        vectors++;
        if (bus.mRD !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_latency1 mRD=%0b expected 0", bus.mRD);
        end
        tick();
        vectors++;
        if (bus.mRD !== 1'b1 || bus.mWR !== 1'b0 || bus.RD_MASK !== 2'b01) begin
            miscompares++;
            $display("FAIL basic_grant mRD=%0b mWR=%0b RD_MASK=%b expected 1 0 01", bus.mRD, bus.mWR, bus.RD_MASK);
        end
        vectors++;
        if (bus.mADDR !== 23'h1000 || bus.mLENGTH !== 9'd256) begin
            miscompares++;
            $display("FAIL basic_req mADDR=%h mLENGTH=%0d expected 1000 256", bus.mADDR, bus.mLENGTH);
        end
        pulse_done(1'b0, 1'b0);
        vectors++;
        if (bus.mRD !== 1'b0 || bus.RD_MASK !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_done mRD=%0b RD_MASK=%b expected 0 00", bus.mRD, bus.RD_MASK);
        end
        tick();
        tick();
        vectors++;
        if (bus.mRD !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_gap mRD=%0b expected 0", bus.mRD);
        end
        tick();
        vectors++;
        if (bus.mRD !== 1'b1 || bus.mADDR !== 23'h1100) begin
            miscompares++;
            $display("FAIL basic_second mRD=%0b mADDR=%h expected 1 1100", bus.mRD, bus.mADDR);
        end
        pulse_done(1'b0, 1'b0);
    endtask

    task automatic test_alternate();
        logic [22:0] exp_addr [4];
        logic [1:0]  exp_mask [4];
        bit ok;
        exp_addr = '{23'h1000, 23'h2000, 23'h1100, 23'h2100};
        exp_mask = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        bus.RD1_ADDR = 23'h1000; bus.RD1_MAX_ADDR = 23'h10000; bus.RD1_LENGTH = 9'd256;
        bus.RD2_ADDR = 23'h2000; bus.RD2_MAX_ADDR = 23'h20000; bus.RD2_LENGTH = 9'd256;
        bus.SEQ_IDLE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_req(ok);
            vectors++;
            if (!ok || bus.mRD !== 1'b1 || bus.RD_MASK !== exp_mask[i] || bus.mADDR !== exp_addr[i]
                || bus.STARVE_CNT !== 3'd0) begin
                miscompares++;
                $display("FAIL alt_grant%0d mRD=%0b RD_MASK=%b mADDR=%h STARVE=%0d expected 1 %b %h 0",
                         i, bus.mRD, bus.RD_MASK, bus.mADDR, bus.STARVE_CNT, exp_mask[i], exp_addr[i]);
            end
            pulse_done(1'b0, 1'b0);
        end
    endtask

    task automatic test_starve();
        bit          exp_wr   [6];
        logic [1:0]  exp_mask [6];
        logic [22:0] exp_addr [6];
        logic [2:0]  exp_cnt  [6];
        bit ok;
        exp_wr   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_mask = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01};
        exp_addr = '{23'h1000, 23'h2000, 23'h1100, 23'h2100, 23'h3000, 23'h1200};
        exp_cnt  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
        do_reset();
        bus.RD1_ADDR = 23'h1000; bus.RD1_MAX_ADDR = 23'h10000; bus.RD1_LENGTH = 9'd256;
        bus.RD2_ADDR = 23'h2000; bus.RD2_MAX_ADDR = 23'h20000; bus.RD2_LENGTH = 9'd256;
        bus.WR1_ADDR = 23'h3000; bus.WR1_MAX_ADDR = 23'h30000; bus.WR1_LENGTH = 9'd256;
        bus.WR1_LEVEL = 16'd300;
        bus.SEQ_IDLE = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_req(ok);
            vectors++;
            if (!ok || bus.mWR !== exp_wr[i] || bus.mRD !== !exp_wr[i]
                || (exp_wr[i] ? bus.WR_MASK : bus.RD_MASK) !== exp_mask[i]) begin
                miscompares++;
                $display("FAIL starve_class%0d mWR=%0b mRD=%0b WR_MASK=%b RD_MASK=%b expected mWR=%0b mask=%b",
                         i, bus.mWR, bus.mRD, bus.WR_MASK, bus.RD_MASK, exp_wr[i], exp_mask[i]);
            end
            vectors++;
            if (bus.mADDR !== exp_addr[i] || bus.STARVE_CNT !== exp_cnt[i]) begin
                miscompares++;
                $display("FAIL starve_cnt%0d mADDR=%h STARVE=%0d expected %h %0d",
                         i, bus.mADDR, bus.STARVE_CNT, exp_addr[i], exp_cnt[i]);
            end
            pulse_done(exp_wr[i], 1'b0);
        end
    endtask

    task automatic test_wrap();
        logic [22:0] exp_addr [3];
        bit ok;
        exp_addr = '{23'h000, 23'h100, 23'h000};
        do_reset();
        bus.RD1_ADDR = 23'h0; bus.RD1_MAX_ADDR = 23'h200; bus.RD1_LENGTH = 9'h100;
        bus.SEQ_IDLE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_req(ok);
            vectors++;
            if (!ok || bus.mRD !== 1'b1 || bus.mADDR !== exp_addr[i]) begin
                miscompares++;
                $display("FAIL wrap_addr%0d mRD=%0b mADDR=%h expected 1 %h", i, bus.mRD, bus.mADDR, exp_addr[i]);
            end
            pulse_done(1'b0, 1'b0);
        end
    endtask

    task automatic test_load();
        bit ok;
        do_reset();
        bus.WR2_ADDR = 23'h400; bus.WR2_MAX_ADDR = 23'h10000; bus.WR2_LENGTH = 9'h100;
        bus.WR2_LEVEL = 16'd300;
        bus.SEQ_IDLE = 1'b1;
        wait_req(ok);
        vectors++;
        if (!ok || bus.mWR !== 1'b1 || bus.WR_MASK !== 2'b10 || bus.mADDR !== 23'h400) begin
            miscompares++;
            $display("FAIL load_first mWR=%0b WR_MASK=%b mADDR=%h expected 1 10 400", bus.mWR, bus.WR_MASK, bus.mADDR);
        end
        pulse_done(1'b0, 1'b0);
        vectors++;
        if (bus.mWR !== 1'b1 || bus.WR_MASK !== 2'b10) begin
            miscompares++;
            $display("FAIL load_ignore_rd_done mWR=%0b WR_MASK=%b expected 1 10", bus.mWR, bus.WR_MASK);
        end
        pulse_done(1'b1, 1'b0);
        wait_req(ok);
        vectors++;
        if (!ok || bus.mWR !== 1'b1 || bus.mADDR !== 23'h500) begin
            miscompares++;
            $display("FAIL load_advance mWR=%0b mADDR=%h expected 1 500", bus.mWR, bus.mADDR);
        end
        pulse_done(1'b1, 1'b1);
        wait_req(ok);
        vectors++;
        if (!ok || bus.mWR !== 1'b1 || bus.mADDR !== 23'h400) begin
            miscompares++;
            $display("FAIL load_reload mWR=%0b mADDR=%h expected 1 400", bus.mWR, bus.mADDR);
        end
        pulse_done(1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        bus.WR2_ADDR = 23'h400; bus.WR2_MAX_ADDR = 23'h10000; bus.WR2_LENGTH = 9'h100;
        bus.WR2_LEVEL = 16'd300;
        bus.SEQ_IDLE = 1'b1;
        wait_req(ok);
        pulse_done(1'b1, 1'b0);
        wait_req(ok);
        vectors++;
        if (!ok || bus.mADDR !== 23'h500) begin
            miscompares++;
            $display("FAIL rstmid_pre mADDR=%h expected 500", bus.mADDR);
        end
        RESET_N = 1'b0;
        #1;
        vectors++;
        if (bus.mWR !== 1'b0 || bus.mRD !== 1'b0 || bus.WR_MASK !== 2'b00 || bus.RD_MASK !== 2'b00) begin
            miscompares++;
            $display("FAIL rstmid_async mWR=%0b mRD=%0b WR_MASK=%b RD_MASK=%b expected 0 0 00 00",
                     bus.mWR, bus.mRD, bus.WR_MASK, bus.RD_MASK);
        end
        tick();
        RESET_N = 1'b1;
        wait_req(ok);
        vectors++;
        if (!ok || bus.mWR !== 1'b1 || bus.mADDR !== 23'h400) begin
            miscompares++;
            $display("FAIL rstmid_fresh mWR=%0b mADDR=%h expected 1 400", bus.mWR, bus.mADDR);
        end
        pulse_done(1'b1, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RESET_N     = 1'b0;
        test_reset();
        test_basic();
        test_alternate();
        test_starve();
        test_wrap();
        test_load();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
